// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_pkg -- shared constants and helpers for the sync_fifo primitive family
// Revision: 1.0
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam string MEM_TYPE_BLOCK = "block";
  localparam string MEM_TYPE_DIST  = "distributed";

  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_ram -- simple dual-port storage, one write port, registered read port
// Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 4,
  parameter string MEM_TYPE   = MEM_TYPE_BLOCK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] w_mem_rd;
  logic [DATA_WIDTH-1:0] rdata_q;

  // The array itself is never reset; only the read register is.
  generate
    if (MEM_TYPE == MEM_TYPE_DIST) begin : g_dist
      (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
      end
      assign w_mem_rd = mem_q[raddr_i];
    end else begin : g_block
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
      end
      assign w_mem_rd = mem_q[raddr_i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= w_mem_rd;
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo -- single-clock pointer FIFO, standard or first-word-fall-through
// Revision: 1.0
// ---------------------------------------------------------------------------
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int    DATA_WIDTH    = 32,
  parameter int    FIFO_DEPTH    = 16,
  parameter int    AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int    AEMPTY_THRESH = 2,
  parameter int    FWFT          = FIFO_MODE_STD,
  parameter string MEM_TYPE      = MEM_TYPE_BLOCK
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = fifo_clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_depth  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_afull  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] c_aempty = CW'(AEMPTY_THRESH);

  logic [CW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, afull_q, aempty_q;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, underflow_q;
  logic          w_wr_acc, w_rd_acc, w_ram_re, w_empty_d;

  assign w_wr_acc = wr_en && !full_q;

  // In FWFT the output register is a pipeline stage: memory is fetched
  // whenever it holds data and the output slot is free or being popped.
  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      logic w_mem_empty;
      assign w_mem_empty = (wptr_q == rptr_q);
      assign w_rd_acc    = rd_en && rd_valid_q;
      assign w_ram_re    = !w_mem_empty && (!rd_valid_q || rd_en);
      assign rd_valid_d  = w_ram_re || (rd_valid_q && !rd_en);
      assign w_empty_d   = !rd_valid_d;
    end else begin : g_std
      assign w_rd_acc    = rd_en && !empty_q;
      assign w_ram_re    = w_rd_acc;
      assign rd_valid_d  = w_rd_acc;
      assign w_empty_d   = (count_d == '0);
    end
  endgenerate

  assign wptr_d  = wptr_q + CW'(w_wr_acc);
  assign rptr_d  = rptr_q + CW'(w_ram_re);
  assign count_d = count_q + CW'(w_wr_acc) - CW'(w_rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == c_depth);
      empty_q     <= w_empty_d;
      afull_q     <= (count_d >= c_afull);
      aempty_q    <= (count_d <= c_aempty);
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= wr_en && full_q;
      underflow_q <= rd_en && empty_q;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW),
    .MEM_TYPE   (MEM_TYPE)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_wr_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .re_i    (w_ram_re),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO that replaces the fixed pass-through FIFO in the primitives library. Provides real pointer-based buffering with independent write and read handshakes, full/empty and programmable almost-full/almost-empty flags, occupancy count, and error pulses. Supports standard (registered-read) and first-word-fall-through (FWFT) modes. Sits between streaming DSP/packet stages in the same clock domain.

## Interface
- DATA_WIDTH, 32, word width in bits (>=1)
- FIFO_DEPTH, 16, capacity in words; power of two, >=4
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserts when count >= this (1..FIFO_DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this (0..FIFO_DEPTH-1)
- FWFT, 0, 0 = standard read, 1 = first-word-fall-through
- MEM_TYPE, "block", "block" or "distributed" storage hint; no functional effect

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- full  out  1  no space; writes rejected
- almost_full  out  1  count >= AFULL_THRESH
- rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data holds a valid word
- empty  out  1  no readable word
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  $clog2(FIFO_DEPTH)+1  words held
- overflow  out  1  one-cycle pulse: wr_en while full
- underflow  out  1  one-cycle pulse: rd_en while empty

## Operation
- Pointers AW+1 bits (AW=$clog2(FIFO_DEPTH)); index = low AW bits; wrap is natural binary roll-over, MSB disambiguates full vs empty.
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Flags sampled as registered at that edge; no full-bypass.
- Simultaneous accepted read+write: count unchanged, both pointers advance.
- Full with wr_en+rd_en: read accepted, write dropped, overflow pulses.
- Empty with wr_en+rd_en: write accepted, read dropped, underflow pulses.
- Dropped operations change no pointer, count or data.
- count = accepted writes minus accepted reads; in FWFT includes the word in the output register. Capacity exactly FIFO_DEPTH in both modes.
- full = (count==FIFO_DEPTH); empty = (count==0) in standard mode, = !rd_valid in FWFT.
- Standard: rd_valid=1 exactly the cycle after an accepted read; rd_data holds last read word otherwise.
- FWFT: rd_data/rd_valid present head word without rd_en; rd_en with rd_valid=1 pops; next word (if any) replaces it with no bubble when memory is non-empty.
- Storage memory is never reset; contents undefined until written.

## Timing
- Reset values: count=0, empty=1, full=0, almost_full=0, almost_empty=1, rd_valid=0, rd_data=0, overflow=0, underflow=0, pointers=0.
- Reset mid-operation: all words discarded; an in-flight read produces no rd_valid after the reset edge.
- All flags and count registered; update on the edge after the accepted operation (one-cycle latency).
- Standard: write at edge N -> empty=0 after N; read accepted at edge M -> data with rd_valid=1 after M.
- FWFT: write into empty FIFO at edge N -> rd_valid=1 and rd_data valid after edge N+1 (2-cycle latency).
- Throughput one word per cycle each direction sustained.

## Structure
- Shared package fifo_pkg: clog2 helper function, MEM_TYPE string constants, mode constants FIFO_MODE_STD/FIFO_MODE_FWFT.
- One sub-module: fifo_ram (simple dual-port, registered read, one write port) so storage can be retargeted per MEM_TYPE.

## Test plan
- Reset, then write 16 words 0x0..0xF (DEPTH=16) -> full=1 after 16th, almost_full=1 after 14th, count=16; 17th write -> overflow pulse, count stays 16.
- Read all 16 (standard) -> rd_data 0x0..0xF in order, rd_valid one cycle after each rd_en, empty=1 after last; extra rd_en -> underflow pulse.
- Concurrent wr_en+rd_en for 100 cycles at count=8 -> count constant 8, data order preserved across pointer wrap.
- Full + simultaneous wr_en/rd_en -> count 15, overflow=1; empty + both -> count 1, underflow=1.
- FWFT=1: single write 0xA5A5A5A5 at edge N -> rd_valid=1, rd_data=0xA5A5A5A5 after N+1 with no rd_en; rd_en pops -> empty=1.
- Assert rst with count=9 and read in flight -> next cycle count=0, empty=1, rd_valid=0.
